// File: rtl/sram_1w1r_mask_ctrl_if.sv
// Port bundle for the 1W1R masked SRAM controller: write port 0, read port 1, status.
interface sram_1w1r_mask_ctrl_if #(
    parameter int DATA_WIDTH = 96,
    parameter int NUM_WMASKS = 3,
    parameter int ADDR_WIDTH = 5
);
    // Handshake: a port request is taken on every rising edge where its csb is low and
    // init_busy is low (no backpressure); dout1_valid is the only response valid and is
    // a single-cycle pulse, with no ready in the return direction.
    logic                  csb0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;
    logic                  init_busy;
    logic                  addr_err;

    modport master (
        output csb0, wmask0, addr0, din0, csb1, addr1,
        input  dout1, dout1_valid, init_busy, addr_err
    );

    modport slave (
        input  csb0, wmask0, addr0, din0, csb1, addr1,
        output dout1, dout1_valid, init_busy, addr_err
    );
endinterface

// File: rtl/sram_1w1r_mask_ctrl.sv
// Behavioural 1W1R SRAM with segmented write mask, 1/2-cycle read latency,
// optional write-to-read bypass, post-reset clear sequencer and sticky address error.
module sram_1w1r_mask_ctrl #(
    parameter int DATA_WIDTH    = 96,
    parameter int WRITE_SIZE    = 32,
    parameter int NUM_WMASKS    = DATA_WIDTH / WRITE_SIZE,
    parameter int DEPTH         = 27,
    parameter int ADDR_WIDTH    = 5,
    parameter int READ_LATENCY  = 1,
    parameter int BYPASS        = 1,
    parameter int INIT_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sram_1w1r_mask_ctrl_if.slave   bus,
    output logic [0:0]             dbg_state
);
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic                  INIT_EN  = (INIT_ON_RESET != 0);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  p1_valid_q, p1_valid_d;
    logic [DATA_WIDTH-1:0] p1_data_q, p1_data_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] dout1_q, dout1_d;
    logic                  addr_err_q, addr_err_d;

    logic                  ready, wr_en, rd_en, wr_inr, rd_inr, collide;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_WMASKS-1:0] mem_wbe;
    logic [DATA_WIDTH-1:0] old_word, rd_word, s_data;
    logic                  s_valid;

    always_comb begin
        ready   = (state_q == ST_READY);
        wr_en   = ready & ~bus.csb0;
        rd_en   = ready & ~bus.csb1;
        wr_inr  = ({1'b0, bus.addr0} < DEPTH_L);
        rd_inr  = ({1'b0, bus.addr1} < DEPTH_L);
        collide = wr_en & wr_inr & rd_inr & (bus.addr0 == bus.addr1);

        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = bus.addr0;
        mem_wdata = bus.din0;
        mem_wbe   = bus.wmask0;

        // The clear sequencer owns the single write port until every word is zeroed.
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
            mem_wbe   = '1;
            if (cnt_q == LAST_IDX) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
        end else if (wr_en && wr_inr) begin
            mem_we = 1'b1;
        end

        old_word = rd_inr ? mem_q[bus.addr1] : '0;
        rd_word  = old_word;
        if (BYPASS != 0 && collide) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (bus.wmask0[i]) rd_word[i*WRITE_SIZE +: WRITE_SIZE] = bus.din0[i*WRITE_SIZE +: WRITE_SIZE];
            end
        end

        p1_valid_d = rd_en;
        p1_data_d  = rd_word;

        if (READ_LATENCY == 1) begin
            s_valid = rd_en;
            s_data  = rd_word;
        end else begin
            s_valid = p1_valid_q;
            s_data  = p1_data_q;
        end

        valid_d    = s_valid;
        dout1_d    = s_valid ? s_data : dout1_q;
        addr_err_d = addr_err_q | (wr_en & ~wr_inr) | (rd_en & ~rd_inr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT_EN ? ST_INIT : ST_READY;
            cnt_q      <= '0;
            p1_valid_q <= 1'b0;
            p1_data_q  <= '0;
            valid_q    <= 1'b0;
            dout1_q    <= '0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p1_valid_q <= p1_valid_d;
            p1_data_q  <= p1_data_d;
            valid_q    <= valid_d;
            dout1_q    <= dout1_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Reset leaves the array contents alone; only the sequencer clears it.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            for (int i = 0; i < NUM_WMASKS; i++) begin
                if (mem_wbe[i]) mem_q[mem_waddr][i*WRITE_SIZE +: WRITE_SIZE] <= mem_wdata[i*WRITE_SIZE +: WRITE_SIZE];
            end
        end
    end

    assign bus.dout1       = dout1_q;
    assign bus.dout1_valid = valid_q;
    assign bus.init_busy   = (state_q == ST_INIT) | (rst & INIT_EN);
    assign bus.addr_err    = addr_err_q;
    assign dbg_state       = state_q;
endmodule
